// File: rtl/inst_queue_if.sv
// Handshake bundle for the instruction queue: host push side, control pop side,
// flush and occupancy status.
interface inst_queue_if #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [INST_W-1:0] instruction_t;

  // Host side
  instruction_t     inst_i;
  logic             inst_valid_i;
  logic             inst_ready_o;

  // Control side
  instruction_t     inst_o;
  logic             inst_valid_o;
  logic             inst_ready_i;

  // Maintenance and status
  logic             flush_i;
  logic [CNT_W-1:0] count_o;
  logic             full_o;
  logic             empty_o;

  modport slave (
    input  inst_i, inst_valid_i, inst_ready_i, flush_i,
    output inst_ready_o, inst_o, inst_valid_o, count_o, full_o, empty_o
  );

  modport master (
    output inst_i, inst_valid_i, inst_ready_i, flush_i,
    input  inst_ready_o, inst_o, inst_valid_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/inst_queue.sv
// In-order instruction buffer between the host stream and the control block.
// Every output is derived from registered state only, so host and control never share a comb path.
module inst_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INST_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  inst_queue_if.slave io
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // A pop in the same cycle never frees a slot for a push: ready looks only at count_q.
  assign push  = io.inst_valid_i && !full;
  assign pop   = io.inst_ready_i && !empty;

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path leaves it unassigned
    // and no latch is inferred; blocking '=' is correct inside combinational logic.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (io.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking '<=' so all registers sample
  // their next value from the same pre-edge state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is cleared on reset so the head reads '0 afterwards; this costs a reset
  // net on every entry and rules out a RAM macro, which is acceptable at this depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !io.flush_i) begin
      mem_q[wr_ptr_q] <= io.inst_i;
    end
  end

  assign io.inst_o       = mem_q[rd_ptr_q];
  assign io.inst_valid_o = !empty;
  assign io.inst_ready_o = !full;
  assign io.count_o      = count_q;
  assign io.full_o       = full;
  assign io.empty_o      = empty;
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a queue model predicts every head, valid, ready and count value.
module tb_inst_queue;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned INST_W = 32;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [INST_W-1:0] sb [$];

  inst_queue_if #(.INST_W(INST_W), .DEPTH(DEPTH)) io ();

  inst_queue #(.DEPTH(DEPTH), .INST_W(INST_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are registered-state only, so they are checked at edge+1 against the model,
  // then the model advances with the inputs applied for this cycle.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
    int  sz;
    logic push_m;
    logic pop_m;
    io.inst_valid_i = v;
    io.inst_i       = d;
    io.inst_ready_i = r;
    io.flush_i      = f;
    sz = sb.size();
    check("valid", io.inst_valid_o, sz != 0);
    check("ready", io.inst_ready_o, sz != DEPTH);
    check("count", io.count_o, sz);
    check("full",  io.full_o, sz == DEPTH);
    check("empty", io.empty_o, sz == 0);
    if (sz != 0) check("head", io.inst_o, sb[0]);
    pop_m  = r && (sz != 0);
    push_m = v && (sz != DEPTH);
    if (f) sb.delete();
    else begin
      if (pop_m)  void'(sb.pop_front());
      if (push_m) sb.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, io.inst_valid_o, 1'b0);
    check({tag, "_ready"}, io.inst_ready_o, 1'b1);
    check({tag, "_count"}, io.count_o, 0);
    check({tag, "_empty"}, io.empty_o, 1'b1);
    check({tag, "_full"},  io.full_o, 1'b0);
    check({tag, "_inst"},  io.inst_o, 0);
  endtask

  initial begin
    rst             = 1'b1;
    io.inst_i       = '0;
    io.inst_valid_i = 1'b0;
    io.inst_ready_i = 1'b0;
    io.flush_i      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check_reset_outputs("idle");

    // Fill to full under stall, offer E while full, then drain in order
    cycle(1'b1, 32'hA000_000A, 1'b0, 1'b0);
    cycle(1'b1, 32'hB000_000B, 1'b0, 1'b0);
    cycle(1'b1, 32'hC000_000C, 1'b0, 1'b0);
    cycle(1'b1, 32'hD000_000D, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hE000_000E, 1'b0, 1'b0);
    check("full_head_held", io.inst_o, 32'hA000_000A);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("drained_empty", io.empty_o, 1'b1);

    // Count 2, concurrent push/pop for 10 cycles across pointer wrap
    cycle(1'b1, 32'h1000_0000, 1'b0, 1'b0);
    cycle(1'b1, 32'h1000_0001, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) cycle(1'b1, 32'h1000_0000 + i, 1'b1, 1'b0);
    check("stream_count", io.count_o, 2);
    check("stream_head", io.inst_o, 32'h1000_000A);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Push into empty with ready high: visible next cycle, gone the one after
    cycle(1'b1, 32'h0000_5A5A, 1'b1, 1'b0);
    check("x_visible", io.inst_o, 32'h0000_5A5A);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("x_gone", io.empty_o, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Count 3, flush with coincident push and pop, then Y becomes head
    cycle(1'b1, 32'h2000_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'h2000_0002, 1'b0, 1'b0);
    cycle(1'b1, 32'h2000_0003, 1'b0, 1'b0);
    cycle(1'b1, 32'h2000_0004, 1'b1, 1'b1);
    check("flush_empty", io.empty_o, 1'b1);
    cycle(1'b1, 32'h3000_00FF, 1'b0, 1'b0);
    check("y_head", io.inst_o, 32'h3000_00FF);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Count 2 under stall, asynchronous reset mid-cycle
    cycle(1'b1, 32'h4000_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'h4000_0002, 1'b0, 1'b0);
    check("pre_rst_count", io.count_o, 2);
    io.inst_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h5000_0077, 1'b0, 1'b0);
    check("post_rst_head", io.inst_o, 32'h5000_0077);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("post_rst_empty", io.empty_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
Instruction buffer that sits directly upstream of the control/decoder stage. It decouples the host instruction stream from the control block's ready/stall back-pressure. Instructions are accepted with a valid/ready handshake on the host side and presented in order to the control block with a valid/ready handshake. It also provides occupancy status and a synchronous flush.

Parameters:
- DEPTH, 4, number of instruction_t entries. Power of two, DEPTH >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- clk_i, in, 1, system clock; all state changes on the rising edge.
- rst_i, in, 1, reset, asynchronous and active-high.
- inst_i, in, $bits(instruction_t), instruction from host.
- inst_valid_i, in, 1, host instruction valid.
- inst_ready_o, out, 1, queue can accept; push occurs when inst_valid_i && inst_ready_o.
- inst_o, out, $bits(instruction_t), head instruction, fed to the control inst_i.
- inst_valid_o, out, 1, head valid, fed to the control inst_valid_i.
- inst_ready_i, in, 1, from the control inst_ready_o; pop occurs when inst_valid_o && inst_ready_i.
- flush_i, in, 1, synchronous discard of all entries.
- count_o, out, CNT_W, current occupancy, 0..DEPTH.
- full_o, out, 1, count_o == DEPTH.
- empty_o, out, 1, count_o == 0.

Behaviour:
- Storage: circular buffer of DEPTH entries, with write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH) bits wide. Pointers wrap modulo DEPTH naturally. count is a separate CNT_W register.
- Reset (rst_i high, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0, all storage entries cleared to '0.
  - Outputs: inst_valid_o = 0, inst_o = '0, count_o = 0, empty_o = 1, full_o = 0, inst_ready_o = 1.
  - Reset asserted mid-operation discards all entries immediately, with no drain.
- inst_ready_o = !full. It depends only on registered state and never combinationally on inst_valid_i or inst_ready_i, so there is no comb path host <-> control.
- inst_valid_o = !empty. inst_o = storage[rd_ptr], which is combinational read of registered state.
  - When empty, inst_o shows the stale entry (or '0 after reset); the bench must not check it.
- Push, when inst_valid_i && !full:
  - storage[wr_ptr] <= inst_i; wr_ptr++.
  - Latency: an instruction pushed in cycle N appears on inst_o/inst_valid_o in cycle N+1. There is no fall-through.
- Pop, when !empty && inst_ready_i: rd_ptr++.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Neither: hold.
- Full: inst_ready_o = 0. inst_valid_i is ignored and inst_i is not written. A pop in the same cycle does not enable a push; the push is taken on the next cycle.
- Empty: inst_ready_i is ignored and no pointer moves. A push while empty is visible next cycle.
- Ordering: strict FIFO. No instruction is duplicated or dropped except by flush or reset.
- Stall from control (inst_ready_i = 0): the head is held stable. inst_o and inst_valid_o must not change while inst_valid_o && !inst_ready_i. The control block relies on this across its multi-cycle issue/drain stalls.
- Flush (flush_i = 1): on the next edge, wr_ptr = rd_ptr = 0 and count = 0.
  - A push or pop coincident with flush is discarded.
  - Storage contents are not cleared.
  - flush_i has priority over push and pop.
- Status: full_o, empty_o and count_o are registered-state derived and glitch-free, with no dependency on the current-cycle handshake inputs.

Test Plan:
- Reset, then idle 3 cycles -> inst_valid_o = 0, inst_ready_o = 1, count_o = 0, empty_o = 1, full_o = 0, inst_o = '0.
- DEPTH = 4, inst_ready_i = 0, push A, B, C, D on consecutive cycles, then offer E -> count_o = 1, 2, 3, 4; full_o = 1; inst_ready_o = 0; E not accepted; inst_o = A held stable. Then inst_ready_i = 1 for 4 cycles -> outputs A, B, C, D in order, then empty_o = 1.
- Count at 2, simultaneous push and pop every cycle for 10 cycles -> count_o stays 2, pointers wrap past DEPTH with no loss or reordering (output sequence equals input sequence delayed by 2).
- Empty queue, push X in cycle N with inst_ready_i = 1 -> inst_valid_o = 0 in cycle N, inst_valid_o = 1 with inst_o = X in N+1, popped at the edge ending N+1, empty again in N+2.
- Count = 3, assert flush_i together with a push and a pop -> next cycle count_o = 0, empty_o = 1, inst_valid_o = 0. The subsequent push Y appears as the head one cycle later.
- Count = 2, assert rst_i asynchronously mid-cycle while inst_ready_i = 0 -> outputs return to reset values immediately, before the next edge. After release, the first push is the only entry delivered.
